vending_fsm_ctrl: RTL and testbench

VENDING_FSM_CTRL -- requirements
Module: vending_fsm_ctrl

---
 rtl/vending_fsm_ctrl_pkg.sv | 34 +++
 rtl/vending_fsm_ctrl_if.sv | 34 +++
 rtl/vending_fsm_ctrl_hold_timer.sv | 31 +++
 rtl/vending_fsm_ctrl.sv | 170 +++++++++++++++++
 tb/tb_vending_fsm_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vending_fsm_ctrl_pkg.sv
// Shared types, widths and price/coin tables for the vending controller.
// The one-hot state encoding doubles as the externally visible state word.
package vending_pkg;

   localparam int TMR_W  = 25;
   localparam int ID_W   = 3;
   localparam int NUM_W  = 2;
   localparam int AMT_W  = 8;
   localparam int COIN_W = 2;
   localparam int ST_W   = 6;

   typedef enum logic [ST_W-1:0] {
      S_IDLE      = 6'h01,
      S_GOODS_ONE = 6'h02,
      S_GOODS_TWO = 6'h04,
      S_PAYMENT   = 6'h08,
      S_CHANGE    = 6'h10,
      S_TEMP      = 6'h20
   } state_e;

   // Index 0 and 7 are "no goods" and cost nothing.
   localparam logic [AMT_W-1:0] PRICE [0:7] = '{
      8'd0, 8'd3, 8'd5, 8'd8, 8'd10, 8'd12, 8'd15, 8'd0
   };

   localparam logic [AMT_W-1:0] COIN_VAL [0:3] = '{
      8'd1, 8'd5, 8'd10, 8'd20
   };

   function automatic logic key_ok(input logic [ID_W-1:0] id, input logic [NUM_W-1:0] num);
      return (id != 3'd0) && (id != 3'd7) && (num != 2'd0);
   endfunction

endpackage

// File: rtl/vending_fsm_ctrl_if.sv
// Front-panel strobes in, registered status out.
// Strobes are one-cycle pulses with no back-pressure: the controller samples every strobe on the edge where it is high.
interface vending_fsm_ctrl_if;
   import vending_pkg::*;

   logic              key_valid;
   logic [ID_W-1:0]   key_id;
   logic [NUM_W-1:0]  key_num;
   logic              confirm;
   logic              cancel;
   logic              coin_valid;
   logic [COIN_W-1:0] coin_code;

   logic [ST_W-1:0]   state;
   logic [ID_W-1:0]   goods_low;
   logic [ID_W-1:0]   goods_high;
   logic [NUM_W-1:0]  goods_num;
   logic [AMT_W-1:0]  total;
   logic [AMT_W-1:0]  paid;
   logic [AMT_W-1:0]  change;
   logic              dispense;
   logic              refund;

   modport master (
      output key_valid, key_id, key_num, confirm, cancel, coin_valid, coin_code,
      input  state, goods_low, goods_high, goods_num, total, paid, change, dispense, refund
   );

   modport slave (
      input  key_valid, key_id, key_num, confirm, cancel, coin_valid, coin_code,
      output state, goods_low, goods_high, goods_num, total, paid, change, dispense, refund
   );

endinterface

// File: rtl/vending_fsm_ctrl_hold_timer.sv
// Loadable down-counter; expire_o is high for the single cycle in which the count sits at 1,
// so a load of N makes expiry act on the Nth edge after the load edge.
module hold_timer
   import vending_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [TMR_W-1:0] load_val_i,
   output logic             expire_o
);

   logic [TMR_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - TMR_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign expire_o = (cnt_q == TMR_W'(1));

endmodule

// File: rtl/vending_fsm_ctrl.sv
// Two-item vending controller: goods selection, payment with inactivity timeout,
// then change and temp dwell phases sharing one hold timer.
module vending_fsm_ctrl
   import vending_pkg::*;
#(
   parameter logic [TMR_W-1:0] TIMEOUT_CYC = 25'd24_999_999,
   parameter logic [TMR_W-1:0] HOLD_CYC    = 25'd24_999_999
)(
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   vending_fsm_ctrl_if.slave  bus
);

   state_e            state_q, state_d;
   logic [ID_W-1:0]   goods_low_q, goods_low_d;
   logic [ID_W-1:0]   goods_high_q, goods_high_d;
   logic [NUM_W-1:0]  goods_num_q, goods_num_d;
   logic [AMT_W-1:0]  total_q, total_d;
   logic [AMT_W-1:0]  paid_q, paid_d;
   logic [AMT_W-1:0]  change_q, change_d;
   logic              dispense_q, dispense_d;
   logic              refund_q, refund_d;

   logic              tmr_load;
   logic [TMR_W-1:0]  tmr_val;
   logic              tmr_expire;

   logic [AMT_W-1:0]  price_sum;
   logic [AMT_W-1:0]  total_calc;
   logic [AMT_W:0]    coin_sum;
   logic [AMT_W-1:0]  paid_new;
   logic              key_good;

   hold_timer u_timer (
      .clk_i      (sys_clk),
      .rst_i      (sys_rst_n),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .expire_o   (tmr_expire)
   );

   assign key_good   = bus.key_valid && key_ok(bus.key_id, bus.key_num);
   assign price_sum  = PRICE[goods_low_q] + PRICE[goods_high_q];
   assign total_calc = AMT_W'(price_sum * AMT_W'(goods_num_q));
   assign coin_sum   = {1'b0, paid_q} + {1'b0, COIN_VAL[bus.coin_code]};
   assign paid_new   = coin_sum[AMT_W] ? '1 : coin_sum[AMT_W-1:0];

   always_comb begin
      state_d      = state_q;
      goods_low_d  = goods_low_q;
      goods_high_d = goods_high_q;
      goods_num_d  = goods_num_q;
      total_d      = total_q;
      paid_d       = paid_q;
      change_d     = change_q;
      dispense_d   = 1'b0;
      refund_d     = refund_q;
      tmr_load     = 1'b0;
      tmr_val      = HOLD_CYC;

      case (state_q)
         S_IDLE: begin
            if (!bus.cancel && !bus.confirm && key_good) begin
               goods_low_d = bus.key_id;
               goods_num_d = bus.key_num;
               state_d     = S_GOODS_ONE;
            end
         end
         S_GOODS_ONE, S_GOODS_TWO: begin
            if (bus.cancel) begin
               goods_low_d  = '0;
               goods_high_d = '0;
               goods_num_d  = '0;
               state_d      = S_IDLE;
            end else if (bus.confirm) begin
               total_d  = total_calc;
               paid_d   = '0;
               tmr_load = 1'b1;
               tmr_val  = TIMEOUT_CYC;
               state_d  = S_PAYMENT;
            end else if (state_q == S_GOODS_ONE && key_good && bus.key_id != goods_low_q) begin
               goods_high_d = bus.key_id;
               state_d      = S_GOODS_TWO;
            end
         end
         S_PAYMENT: begin
            // Cancel wins over a coin in the same cycle; that coin is simply lost.
            if (bus.cancel || (!bus.coin_valid && tmr_expire)) begin
               change_d = paid_q;
               refund_d = 1'b1;
               tmr_load = 1'b1;
               state_d  = S_CHANGE;
            end else if (bus.coin_valid) begin
               paid_d   = paid_new;
               tmr_load = 1'b1;
               if (paid_new >= total_q) begin
                  change_d   = paid_new - total_q;
                  dispense_d = 1'b1;
                  state_d    = S_CHANGE;
               end else begin
                  tmr_val = TIMEOUT_CYC;
               end
            end
         end
         S_CHANGE: begin
            if (tmr_expire) begin
               tmr_load = 1'b1;
               state_d  = S_TEMP;
            end
         end
         S_TEMP: begin
            if (tmr_expire) begin
               goods_low_d  = '0;
               goods_high_d = '0;
               goods_num_d  = '0;
               total_d      = '0;
               paid_d       = '0;
               change_d     = '0;
               refund_d     = 1'b0;
               state_d      = S_IDLE;
            end
         end
         default: begin
            goods_low_d  = '0;
            goods_high_d = '0;
            goods_num_d  = '0;
            total_d      = '0;
            paid_d       = '0;
            change_d     = '0;
            refund_d     = 1'b0;
            state_d      = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst_n) begin
         state_q      <= S_IDLE;
         goods_low_q  <= '0;
         goods_high_q <= '0;
         goods_num_q  <= '0;
         total_q      <= '0;
         paid_q       <= '0;
         change_q     <= '0;
         dispense_q   <= 1'b0;
         refund_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         goods_low_q  <= goods_low_d;
         goods_high_q <= goods_high_d;
         goods_num_q  <= goods_num_d;
         total_q      <= total_d;
         paid_q       <= paid_d;
         change_q     <= change_d;
         dispense_q   <= dispense_d;
         refund_q     <= refund_d;
      end
   end

   assign bus.state      = state_q;
   assign bus.goods_low  = goods_low_q;
   assign bus.goods_high = goods_high_q;
   assign bus.goods_num  = goods_num_q;
   assign bus.total      = total_q;
   assign bus.paid       = paid_q;
   assign bus.change     = change_q;
   assign bus.dispense   = dispense_q;
   assign bus.refund     = refund_q;

endmodule

// File: tb/tb_vending_fsm_ctrl.sv
// Bench for vending_fsm_ctrl: directed purchases; each expected output word is queued
// as stimulus is issued and a negedge monitor pops one entry per observed output change.
module tb_vending_fsm_ctrl;
   localparam int W = 40;

   logic sys_clk;
   logic sys_rst_n;

   vending_fsm_ctrl_if bus ();

   vending_fsm_ctrl #(
      .TIMEOUT_CYC (25'd8),
      .HOLD_CYC    (25'd3)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus)
   );

   logic [W-1:0] exp_q[$];
   logic [W-1:0] prev_vec;
   logic         mon_en;
   int           checks;
   int           failures;

   function automatic logic [W-1:0] mk(input logic [5:0] st, input logic [2:0] lo, input logic [2:0] hi,
                                       input logic [1:0] num, input logic [7:0] tot, input logic [7:0] pd,
                                       input logic [7:0] ch, input logic disp, input logic rf);
      return {st, lo, hi, num, tot, pd, ch, disp, rf};
   endfunction

   function automatic logic [W-1:0] cur_vec();
      return {bus.state, bus.goods_low, bus.goods_high, bus.goods_num, bus.total,
              bus.paid, bus.change, bus.dispense, bus.refund};
   endfunction

   logic [W-1:0] reset_vec;
   assign reset_vec = mk(6'h01, 3'd0, 3'd0, 2'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);

   // clock / reset
   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // monitor / scoreboard
   always @(negedge sys_clk) begin
      logic [W-1:0] cur;
      logic [W-1:0] exp;
      cur = cur_vec();
      if (!mon_en) begin
         prev_vec = reset_vec;
      end else if (cur !== prev_vec) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_output actual=%h required=no_change", cur);
         end else begin
            exp = exp_q.pop_front();
            if (cur !== exp) begin
               failures++;
               $display("FAIL scoreboard actual=%h required=%h", cur, exp);
            end
         end
         prev_vec = cur;
      end
   end

   // driver tasks (called at posedge+1)
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   task automatic strobe(input logic kv, input logic [2:0] id, input logic [1:0] num,
                         input logic cf, input logic cn, input logic cv, input logic [1:0] cc);
      bus.key_valid  = kv;
      bus.key_id     = id;
      bus.key_num    = num;
      bus.confirm    = cf;
      bus.cancel     = cn;
      bus.coin_valid = cv;
      bus.coin_code  = cc;
      idle(1);
      bus.key_valid  = 1'b0;
      bus.confirm    = 1'b0;
      bus.cancel     = 1'b0;
      bus.coin_valid = 1'b0;
   endtask

   task automatic key(input logic [2:0] id, input logic [1:0] num);
      strobe(1'b1, id, num, 1'b0, 1'b0, 1'b0, 2'd0);
   endtask

   task automatic confirm_s();
      strobe(1'b0, 3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0);
   endtask

   task automatic cancel_s();
      strobe(1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0);
   endtask

   task automatic coin(input logic [1:0] cc, input logic with_cancel);
      strobe(1'b0, 3'd0, 2'd0, 1'b0, with_cancel, 1'b1, cc);
   endtask

   task automatic check_left(input int n, input string name);
      checks++;
      if (exp_q.size() != n) begin
         failures++;
         $display("FAIL %s pending=%0d required=%0d", name, exp_q.size(), n);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      mon_en   = 1'b0;
      sys_rst_n = 1'b1;
      bus.key_valid = 1'b0; bus.key_id = '0; bus.key_num = '0;
      bus.confirm = 1'b0; bus.cancel = 1'b0; bus.coin_valid = 1'b0; bus.coin_code = '0;
      idle(3);
      checks++;
      if (cur_vec() !== reset_vec) begin
         failures++;
         $display("FAIL reset_state actual=%h required=%h", cur_vec(), reset_vec);
      end
      sys_rst_n = 1'b0;
      mon_en = 1'b1;
      idle(2);

      // two items, exact payment: total (5+10)*2 = 30
      exp_q.push_back(mk(6'h02, 3'd2, 3'd0, 2'd2, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0));
      key(3'd2, 2'd2);
      exp_q.push_back(mk(6'h04, 3'd2, 3'd4, 2'd2, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0));
      key(3'd4, 2'd1);
      exp_q.push_back(mk(6'h08, 3'd2, 3'd4, 2'd2, 8'd30, 8'd0, 8'd0, 1'b0, 1'b0));
      confirm_s();
      exp_q.push_back(mk(6'h08, 3'd2, 3'd4, 2'd2, 8'd30, 8'd20, 8'd0, 1'b0, 1'b0));
      coin(2'b11, 1'b0);
      exp_q.push_back(mk(6'h10, 3'd2, 3'd4, 2'd2, 8'd30, 8'd30, 8'd0, 1'b1, 1'b0));
      exp_q.push_back(mk(6'h10, 3'd2, 3'd4, 2'd2, 8'd30, 8'd30, 8'd0, 1'b0, 1'b0));
      exp_q.push_back(mk(6'h20, 3'd2, 3'd4, 2'd2, 8'd30, 8'd30, 8'd0, 1'b0, 1'b0));
      exp_q.push_back(reset_vec);
      coin(2'b10, 1'b0);
      idle(3);
      check_left(2, "change_dwell_early");
      idle(1);
      check_left(1, "change_dwell_late");
      idle(3);
      check_left(0, "sale_a_drain");

      // single item with change: total 15, paid 20
      exp_q.push_back(mk(6'h02, 3'd6, 3'd0, 2'd1, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0));
      key(3'd6, 2'd1);
      exp_q.push_back(mk(6'h08, 3'd6, 3'd0, 2'd1, 8'd15, 8'd0, 8'd0, 1'b0, 1'b0));
      confirm_s();
      exp_q.push_back(mk(6'h08, 3'd6, 3'd0, 2'd1, 8'd15, 8'd5, 8'd0, 1'b0, 1'b0));
      coin(2'b01, 1'b0);
      exp_q.push_back(mk(6'h08, 3'd6, 3'd0, 2'd1, 8'd15, 8'd10, 8'd0, 1'b0, 1'b0));
      coin(2'b01, 1'b0);
      exp_q.push_back(mk(6'h10, 3'd6, 3'd0, 2'd1, 8'd15, 8'd20, 8'd5, 1'b1, 1'b0));
      exp_q.push_back(mk(6'h10, 3'd6, 3'd0, 2'd1, 8'd15, 8'd20, 8'd5, 1'b0, 1'b0));
      exp_q.push_back(mk(6'h20, 3'd6, 3'd0, 2'd1, 8'd15, 8'd20, 8'd5, 1'b0, 1'b0));
      exp_q.push_back(reset_vec);
      coin(2'b10, 1'b0);
      idle(8);
      check_left(0, "sale_b_drain");

      // payment timeout: total 9, paid 5, refund
      exp_q.push_back(mk(6'h02, 3'd1, 3'd0, 2'd3, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0));
      key(3'd1, 2'd3);
      exp_q.push_back(mk(6'h08, 3'd1, 3'd0, 2'd3, 8'd9, 8'd0, 8'd0, 1'b0, 1'b0));
      confirm_s();
      exp_q.push_back(mk(6'h08, 3'd1, 3'd0, 2'd3, 8'd9, 8'd5, 8'd0, 1'b0, 1'b0));
      exp_q.push_back(mk(6'h10, 3'd1, 3'd0, 2'd3, 8'd9, 8'd5, 8'd5, 1'b0, 1'b1));
      exp_q.push_back(mk(6'h20, 3'd1, 3'd0, 2'd3, 8'd9, 8'd5, 8'd5, 1'b0, 1'b1));
      exp_q.push_back(reset_vec);
      coin(2'b01, 1'b0);
      idle(8);
      check_left(3, "timeout_early");
      idle(1);
      check_left(2, "timeout_late");
      idle(6);
      check_left(0, "sale_c_drain");

      // coin together with cancel: coin dropped, refund of 10
      exp_q.push_back(mk(6'h02, 3'd6, 3'd0, 2'd2, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0));
      key(3'd6, 2'd2);
      exp_q.push_back(mk(6'h08, 3'd6, 3'd0, 2'd2, 8'd30, 8'd0, 8'd0, 1'b0, 1'b0));
      confirm_s();
      exp_q.push_back(mk(6'h08, 3'd6, 3'd0, 2'd2, 8'd30, 8'd10, 8'd0, 1'b0, 1'b0));
      coin(2'b10, 1'b0);
      exp_q.push_back(mk(6'h10, 3'd6, 3'd0, 2'd2, 8'd30, 8'd10, 8'd10, 1'b0, 1'b1));
      exp_q.push_back(mk(6'h20, 3'd6, 3'd0, 2'd2, 8'd30, 8'd10, 8'd10, 1'b0, 1'b1));
      exp_q.push_back(reset_vec);
      coin(2'b11, 1'b1);
      idle(8);
      check_left(0, "sale_d_drain");

      // invalid keys in IDLE are ignored
      key(3'd0, 2'd1);
      key(3'd7, 2'd2);
      key(3'd3, 2'd0);
      idle(1);
      check_left(0, "invalid_keys_idle");

      // repeated / invalid keys in GOODS_one ignored, then cancel
      exp_q.push_back(mk(6'h02, 3'd3, 3'd0, 2'd2, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0));
      key(3'd3, 2'd2);
      key(3'd3, 2'd1);
      key(3'd5, 2'd0);
      key(3'd0, 2'd1);
      idle(1);
      check_left(0, "invalid_keys_goods_one");
      exp_q.push_back(reset_vec);
      cancel_s();

      // GOODS_two ignores keys; reset in PAYMENT aborts without dispense
      exp_q.push_back(mk(6'h02, 3'd5, 3'd0, 2'd1, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0));
      key(3'd5, 2'd1);
      exp_q.push_back(mk(6'h04, 3'd5, 3'd1, 2'd1, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0));
      key(3'd1, 2'd1);
      key(3'd2, 2'd1);
      exp_q.push_back(mk(6'h08, 3'd5, 3'd1, 2'd1, 8'd15, 8'd0, 8'd0, 1'b0, 1'b0));
      confirm_s();
      exp_q.push_back(mk(6'h08, 3'd5, 3'd1, 2'd1, 8'd15, 8'd10, 8'd0, 1'b0, 1'b0));
      coin(2'b10, 1'b0);
      exp_q.push_back(reset_vec);
      sys_rst_n = 1'b1;
      idle(1);
      sys_rst_n = 1'b0;
      idle(1);
      check_left(0, "reset_mid_payment");
      idle(12);

      check_left(0, "final_drain");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
